// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    OUTPUT,
    ERROR
  } seq_state_t;

  localparam int STAGE_CONV   = 0;
  localparam int STAGE_POOL   = 1;
  localparam int STAGE_DENSE  = 2;
  localparam int STAGE_ARGMAX = 3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/cnn_layer_sequencer_seq_watchdog.sv
// Per-stage watchdog: saturating cycle counter with a timeout flag at TIMEOUT_CYCLES-1.
module seq_watchdog
  import cnn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] count;

  // Saturates at all-ones so a stalled stage can never wrap back below the limit.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

  assign timeout = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Frame-level layer sequencer: start/done walk over the engines, watchdog, result handshake.
// Optional SEQ_PERF_EN adds a per-frame cycle count output (frame_cycles).
module cnn_layer_sequencer
  import cnn_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int STAGE_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_valid,
  output logic                  frame_ready,
  output logic [NUM_STAGES-1:0] stage_start,
  input  logic [NUM_STAGES-1:0] stage_done,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic                  busy,
  output logic [STAGE_W-1:0]    cur_stage,
  output logic                  error,
  input  logic                  err_clear
`ifdef SEQ_PERF_EN
  ,
  output logic [31:0]           frame_cycles
`endif
);

  localparam logic [NUM_STAGES-1:0] STAGE_ONE = 1;
  localparam logic [STAGE_W-1:0]    LAST_STAGE = STAGE_W'(NUM_STAGES - 1);

  seq_state_t state;
  logic       timeout;
  logic       accept;
  logic       stage_hit;
  logic       last_stage;

  assign accept     = (state == IDLE) && frame_valid && frame_ready;
  assign stage_hit  = (state == RUN) && stage_done[cur_stage];
  assign last_stage = (cur_stage == LAST_STAGE);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == LAUNCH),
    .enable (state == RUN),
    .timeout(timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      frame_ready  <= 1'b1;
      stage_start  <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      cur_stage    <= '0;
      error        <= 1'b0;
    end else begin
      stage_start <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            cur_stage   <= '0;
            busy        <= 1'b1;
            frame_ready <= 1'b0;
            state       <= LAUNCH;
          end
        end
        LAUNCH: begin
          stage_start <= STAGE_ONE << cur_stage;
          state       <= RUN;
        end
        RUN: begin
          // Done has priority over a timeout landing on the same cycle.
          if (stage_hit) begin
            if (last_stage) begin
              result_valid <= 1'b1;
              state        <= OUTPUT;
            end else begin
              cur_stage <= cur_stage + STAGE_W'(1);
              state     <= LAUNCH;
            end
          end else if (timeout) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= ERROR;
          end
        end
        OUTPUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            frame_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        ERROR: begin
          if (err_clear) begin
            error       <= 1'b0;
            cur_stage   <= '0;
            frame_ready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_EN
  logic [31:0] cycle_count;
  logic [31:0] count_next;

  assign count_next = (cycle_count == 32'hFFFF_FFFF) ? cycle_count : cycle_count + 32'd1;

  // The captured value includes the cycle on which OUTPUT is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count  <= '0;
      frame_cycles <= '0;
    end else begin
      if (accept) begin
        cycle_count <= '0;
      end else if (busy) begin
        cycle_count <= count_next;
      end
      if (stage_hit && last_stage) begin
        frame_cycles <= count_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: expected start/result/error events are queued, a monitor pops them.
module tb_cnn_layer_sequencer;
  import cnn_pkg::*;

  localparam int NS = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [NS-1:0] stage_start;
  logic [NS-1:0] stage_done;
  logic [NS-1:0] model_done = '0;
  logic [NS-1:0] inject = '0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          busy;
  logic [1:0]    cur_stage;
  logic          error;
  logic          err_clear = 1'b0;
`ifdef SEQ_PERF_EN
  logic [31:0]   frame_cycles;
`endif

  assign stage_done = model_done | inject;

  cnn_layer_sequencer #(
    .NUM_STAGES    (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .stage_start (stage_start),
    .stage_done  (stage_done),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy),
    .cur_stage   (cur_stage),
    .error       (error),
    .err_clear   (err_clear)
`ifdef SEQ_PERF_EN
    ,
    .frame_cycles(frame_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 0 start, 1 result, 2 error
    int val;
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic log_event(input int kind, input int val);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got kind=%0d val=%0d cycle=%0d, expected none", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.val == val && e.cyc == cyc) begin
        n_pass++;
        $display("event kind=%0d val=%0d cycle=%0d ok", kind, val, cyc);
      end else begin
        $display("FAIL event: got kind=%0d val=%0d cycle=%0d, expected kind=%0d val=%0d cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // Engine model: done pulse lat[i] cycles after its start (lat < 0 means never).
  int lat[NS];
  int st_cyc[NS];
  bit armed[NS];

  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (reset) armed[i] = 1'b0;
      else if (stage_start[i]) begin
        armed[i]  = 1'b1;
        st_cyc[i] = cyc;
      end
      model_done[i] = armed[i] && (lat[i] >= 0) && (cyc == st_cyc[i] + lat[i]);
      if (model_done[i]) armed[i] = 1'b0;
    end
  end

  // Monitor
  logic prev_rv = 1'b0;
  logic prev_err = 1'b0;

  always @(negedge clk) begin
    int idx;
    if (!reset) begin
      if (stage_start != '0) begin
        idx = 99;
        if ($onehot(stage_start)) begin
          for (int i = 0; i < NS; i++) if (stage_start[i]) idx = i;
        end
        log_event(0, idx);
      end
      if (result_valid && !prev_rv) begin
`ifdef SEQ_PERF_EN
        log_event(1, int'(frame_cycles));
`else
        log_event(1, int'(cur_stage));
`endif
      end
      if (error && !prev_err) log_event(2, int'(cur_stage));
    end
    prev_rv  = result_valid;
    prev_err = error;
  end

  task automatic push(input int k, input int v, input int c);
    ev_t e;
    e.kind = k;
    e.val  = v;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Next start comes 2 cycles after done; result_valid 1 cycle after the last done.
  task automatic push_frame(input int t, input int nstart);
    int s;
    int r;
    s = t + 1;
    for (int i = 0; i < nstart; i++) begin
      push(0, i, s);
      if (i < nstart - 1) s = s + lat[i] + 2;
    end
    if (nstart == NS) begin
      r = s + lat[NS-1] + 1;
`ifdef SEQ_PERF_EN
      push(1, r - t, r);
`else
      push(1, NS - 1, r);
`endif
    end
  endtask

  task automatic accept(output int t);
    check("frame_ready_before_accept", frame_ready, 1);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    t = cyc;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic wait_sig(input string name, input bit want_err);
    int n;
    n = 0;
    while (!(want_err ? error : result_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(want_err ? error : result_valid), 1);
  endtask

  task automatic handshake(input string name);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({name, "_frame_ready"}, frame_ready, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_result_valid"}, result_valid, 0);
  endtask

  task automatic nominal(input string name);
    int t;
    accept(t);
    push_frame(t, NS);
    wait_sig({name, "_result"}, 1'b0);
    handshake(name);
  endtask

  task automatic check_reset_values(input string name);
    check({name, "_frame_ready"}, frame_ready, 1);
    check({name, "_stage_start"}, int'(stage_start), 0);
    check({name, "_result_valid"}, result_valid, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_cur_stage"}, int'(cur_stage), 0);
    check({name, "_error"}, error, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int t;
    int bp_bad;
    for (int i = 0; i < NS; i++) lat[i] = 10;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    nominal("nominal");

    // Backpressure on the result
    accept(t);
    push_frame(t, NS);
    wait_sig("bp_result", 1'b0);
    bp_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!(result_valid && !frame_ready)) bp_bad++;
    end
    check("backpressure_hold_bad_cycles", bp_bad, 0);
    handshake("bp");

    // Spurious dones: stage 0 during LAUNCH, stage 2 while stage 0 runs
    accept(t);
    push_frame(t, NS);
    inject = 4'b0001;
    @(negedge clk);
    inject = '0;
    @(negedge clk);
    check("spurious_cur_stage", int'(cur_stage), 0);
    inject = 4'b0100;
    @(negedge clk);
    inject = '0;
    wait_sig("spurious_result", 1'b0);
    handshake("spurious");

    // Timeout in stage 1
    lat[1] = -1;
    accept(t);
    push_frame(t, 2);
    push(2, 1, t + 13 + TO);
    wait_sig("timeout_error", 1'b1);
    check("timeout_busy", busy, 0);
    check("timeout_frame_ready", frame_ready, 0);
    repeat (5) @(negedge clk);
    check("timeout_error_sticky", error, 1);
    check("timeout_cur_stage", int'(cur_stage), 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("err_clear_frame_ready", frame_ready, 1);
    check("err_clear_error", error, 0);
    check("err_clear_cur_stage", int'(cur_stage), 0);
    lat[1] = 10;
    nominal("after_error");

    // Done lands on the watchdog's last cycle
    lat[0] = TO - 1;
    nominal("coincide");
    check("coincide_error", error, 0);
    lat[0] = 10;

    // Reset while stage 2 runs
    accept(t);
    push_frame(t, 3);
    while (cyc < t + 28) @(negedge clk);
    check("midrun_cur_stage", int'(cur_stage), 2);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midrun_reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nominal("after_reset");

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
